regfile_write_bank: RTL and testbench
=====================================

// Module: regfile_write_bank
//
// PURPOSE
//   Write side of the 32 x 32-bit register file: decodes a 5-bit write address to one-hot and updates the addressed register.
//   Exports every register on a flat bus, which the 32:1 read muxes select from.
//   Write requests use a valid/ready handshake.
//   A bulk-clear sequencer zeroes r1..r31, one register per cycle, for processor/multdiv re-init.
//   r0 is hardwired to zero.
//
// PARAMETERS
//   WIDTH   32   data width of each register
//   NREGS   32   number of registers (fixed; ADDR_W = log2(NREGS))
//   ADDR_W  5    write-address width
//
// PORTS
//   clock      in   1             rising-edge clock; all state updates on posedge
//   reset      in   1             synchronous, ACTIVE-LOW (0 at posedge = reset)
//   wr_valid   in   1             write request present
//   wr_addr    in   ADDR_W        destination register index
//   wr_data    in   WIDTH         value to write
//   wr_ready   out  1             bank can accept a write this cycle
//   clr_start  in   1             pulse: begin bulk clear of r1..r31
//   clr_busy   out  1             bulk clear in progress
//   wr_onehot  out  NREGS         registered one-hot decode of last accepted write
//   regs_flat  out  NREGS*WIDTH   r[i] on bits [i*WIDTH +: WIDTH]
//
// BEHAVIOUR
//   - Reset (reset==0 at posedge):
//     - all registers = 0; state = IDLE; clear counter = 0.
//     - Outputs: wr_ready=1 from the first cycle after reset deasserts; clr_busy=0; wr_onehot=0; regs_flat=0.
//     - While reset is held low: wr_ready=0.
//     - Reset mid-clear: sweep aborts, all registers = 0, state = IDLE.
//   - FSM has two states, IDLE and CLEAR.
//     - IDLE: wr_ready=1, clr_busy=0.
//     - CLEAR: wr_ready=0, clr_busy=1.
//   - Write accept: wr_valid && wr_ready at posedge.
//     - r[wr_addr] <= wr_data, unless wr_addr==0; r0 never changes.
//     - wr_onehot <= 1<<wr_addr, including bit 0 for an r0 write.
//     - No accept: wr_onehot holds.
//   - Latency: new value is on regs_flat the cycle after the accepting edge.
//     - Back-to-back writes at one per cycle are allowed.
//     - Same address twice: the later write wins.
//   - IDLE -> CLEAR on clr_start==1 at posedge; counter <= 1.
//   - In CLEAR, each posedge clears r[counter] and increments counter.
//     - When counter==31 the edge clears r31 and returns to IDLE.
//     - clr_busy is high for exactly 31 cycles.
//   - clr_start during CLEAR is ignored; it neither restarts nor extends the sweep.
//   - wr_valid during CLEAR: not accepted; the requester holds the request until wr_ready.
//   - wr_valid && clr_start in the same IDLE cycle:
//     - the write commits at that edge, then the sweep starts;
//     - the written register (if nonzero index) ends at 0.
//   - Registers not yet swept keep their values; regs_flat updates progressively.
//   - wr_data is stored unmodified (no sign/zero extension). X on wr_addr while not accepting has no effect.
//
// TESTING
//   1. Release reset -> wr_ready=1, clr_busy=0, regs_flat=0, wr_onehot=0.
//   2. Write addr=5, data=0xDEADBEEF -> next cycle r5=0xDEADBEEF, wr_onehot=0x00000020, all other registers 0.
//   3. Write addr=0, data=0xFFFFFFFF -> r0 stays 0, wr_onehot=0x00000001.
//   4. Back-to-back writes r31=0x1, r31=0x2, r1=0x3 on consecutive cycles -> r31=0x2, r1=0x3.
//   5. Fill r1..r31 with i, pulse clr_start:
//      - clr_busy high 31 cycles; wr_ready low throughout;
//      - writes offered during the sweep stall and commit after it;
//      - r1..r31 = 0 at end.
//   6. Start clear, assert reset at cycle 10 -> all registers 0, IDLE, wr_ready=1 after release.
//      Also: wr_valid(addr=7) with clr_start in the same cycle -> r7=0 after the sweep.

Source files
------------

// File: rtl/regfile_write_bank.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_bank
// Description : Write side of the 32 x 32-bit register file. It decodes each
//               accepted write, sweeps r1..r31 to zero on request, and keeps
//               r0 hardwired to zero.
// Revision    : 1.0
// ============================================================================
module regfile_write_bank #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wr_valid,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     wr_ready,
  input  logic                     clr_start,
  output logic                     clr_busy,
  output logic [NREGS-1:0]         wr_onehot,
  output logic [NREGS*WIDTH-1:0]   regs_flat
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [NREGS-1:0]    wr_onehot_q;
  logic                w_accept;
  logic [NREGS-1:0]    w_dec;

  // Holding reset low must also block the handshake, not only the state.
  assign wr_ready  = reset && (state_q == S_IDLE);
  assign clr_busy  = (state_q == S_CLEAR);
  assign w_accept  = wr_valid && wr_ready;
  assign w_dec     = NREGS'(1) << wr_addr;
  assign wr_onehot = wr_onehot_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (clr_start) begin
          state_d = S_CLEAR;
          cnt_d   = ADDR_W'(1);
        end
      end
      S_CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(NREGS - 1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wr_onehot_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (w_accept) begin
        wr_onehot_q <= w_dec;
      end
    end
  end

  // Writes are only accepted in IDLE, so a write and a sweep never hit the same edge.
  generate
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
      if (i == 0) begin : g_zero
        assign regs_flat[i*WIDTH +: WIDTH] = '0;
      end else begin : g_store
        logic [WIDTH-1:0] r_q;
        always_ff @(posedge clock) begin
          if (!reset) begin
            r_q <= '0;
          end else if ((state_q == S_CLEAR) && (cnt_q == ADDR_W'(i))) begin
            r_q <= '0;
          end else if (w_accept && w_dec[i]) begin
            r_q <= wr_data;
          end
        end
        assign regs_flat[i*WIDTH +: WIDTH] = r_q;
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_write_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_write_bank
// Description : Directed and random stimulus for regfile_write_bank, checked
//               against an array-based model of the register file.
// Revision    : 1.0
// ============================================================================
module tb_regfile_write_bank;

  logic          clk;
  logic          rst_n;
  logic          valid;
  logic [4:0]    addr;
  logic [31:0]   data;
  logic          start;
  logic          wr_ready;
  logic          clr_busy;
  logic [31:0]   wr_onehot;
  logic [1023:0] regs_flat;

  int n_vec;
  int n_err;

  // Model: register contents, last decode, and sweep cycles still to run.
  logic [31:0] m_reg [32];
  logic [31:0] m_oh;
  int          m_left;
  bit          last_acc;

  regfile_write_bank #(.WIDTH(32), .NREGS(32), .ADDR_W(5)) dut (
    .clock     (clk),
    .reset     (rst_n),
    .wr_valid  (valid),
    .wr_addr   (addr),
    .wr_data   (data),
    .wr_ready  (wr_ready),
    .clr_start (start),
    .clr_busy  (clr_busy),
    .wr_onehot (wr_onehot),
    .regs_flat (regs_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge: advance the model from the inputs seen at the edge, then compare.
  task automatic cyc();
    bit acc;
    @(posedge clk);
    acc = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_reg[i] = '0;
      m_oh   = '0;
      m_left = 0;
    end else begin
      if (valid && m_left == 0) begin
        acc = 1'b1;
        if (addr != 5'd0) m_reg[addr] = data;
        m_oh = 32'h1 << addr;
      end
      if (m_left > 0) begin
        m_reg[32 - m_left] = '0;
        m_left--;
      end else if (start) begin
        m_left = 31;
      end
    end
    last_acc = acc;
    #1;
    check_value("wr_ready", {31'b0, wr_ready}, {31'b0, (rst_n && m_left == 0)});
    check_value("clr_busy", {31'b0, clr_busy}, {31'b0, (m_left > 0)});
    check_value("wr_onehot", wr_onehot, m_oh);
    for (int i = 0; i < 32; i++)
      check_value($sformatf("r%0d", i), regs_flat[i*32 +: 32], m_reg[i]);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    valid = 1'b1;
    addr  = a;
    data  = d;
    cyc();
    valid = 1'b0;
  endtask

  initial begin
    int nb;
    int guard;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 32; i++) m_reg[i] = '0;
    m_oh     = '0;
    m_left   = 0;
    last_acc = 1'b0;
    rst_n    = 1'b0;
    valid    = 1'b0;
    addr     = '0;
    data     = '0;
    start    = 1'b0;

    // Reset held, then released.
    repeat (3) cyc();
    rst_n = 1'b1;
    #1;
    check_value("ready_after_release", {31'b0, wr_ready}, 32'h1);
    cyc();

    wr(5'd5, 32'hDEADBEEF);
    check_value("t2_r5", regs_flat[5*32 +: 32], 32'hDEADBEEF);
    check_value("t2_onehot", wr_onehot, 32'h0000_0020);

    wr(5'd0, 32'hFFFFFFFF);
    check_value("t3_r0", regs_flat[31:0], 32'h0);
    check_value("t3_onehot", wr_onehot, 32'h0000_0001);

    wr(5'd31, 32'h1);
    wr(5'd31, 32'h2);
    wr(5'd1, 32'h3);
    check_value("t4_r31", regs_flat[31*32 +: 32], 32'h2);
    check_value("t4_r1", regs_flat[1*32 +: 32], 32'h3);

    // Fill, sweep, with a write stalled across the sweep and a stray clr_start.
    for (int i = 1; i < 32; i++) wr(5'(i), 32'(i));
    start = 1'b1;
    cyc();
    start = 1'b0;
    nb = clr_busy ? 1 : 0;
    valid = 1'b1;
    addr  = 5'd9;
    data  = 32'hA5A5_5A5A;
    guard = 0;
    last_acc = 1'b0;
    while (!last_acc && guard < 40) begin
      start = (guard == 5);
      cyc();
      if (clr_busy) nb++;
      guard++;
    end
    valid = 1'b0;
    start = 1'b0;
    check_value("t5_no_timeout", {31'b0, last_acc}, 32'h1);
    check_value("t5_busy_cycles", 32'(nb), 32'd31);
    check_value("t5_r9", regs_flat[9*32 +: 32], 32'hA5A5_5A5A);
    check_value("t5_r30", regs_flat[30*32 +: 32], 32'h0);

    // Reset in the middle of a sweep.
    wr(5'd20, 32'h1234_5678);
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (9) cyc();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
    check_value("t6_ready", {31'b0, wr_ready}, 32'h1);
    check_value("t6_r20", regs_flat[20*32 +: 32], 32'h0);

    // Write and clear start on the same edge.
    valid = 1'b1;
    addr  = 5'd7;
    data  = 32'hCAFE_F00D;
    start = 1'b1;
    cyc();
    valid = 1'b0;
    start = 1'b0;
    check_value("t6b_r7_written", regs_flat[7*32 +: 32], 32'hCAFE_F00D);
    repeat (31) cyc();
    check_value("t6b_r7_swept", regs_flat[7*32 +: 32], 32'h0);
    check_value("t6b_idle", {31'b0, clr_busy}, 32'h0);

    // Random traffic; a stalled request is held until accepted.
    for (int n = 0; n < 2500; n++) begin
      if (!(valid && !last_acc)) begin
        valid = 1'($urandom_range(0, 1));
        addr  = 5'($urandom);
        data  = $urandom;
      end
      start = ($urandom_range(0, 39) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      cyc();
    end
    rst_n = 1'b1;
    valid = 1'b0;
    start = 1'b0;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
